// File: rtl/prog_clock_divider.sv
// Runtime-programmable clock divider / tick generator with glitch-free reload at period boundaries.
// Optional macro DIVIDER_SYNC_EN adds an i_sync input for phase alignment of several dividers.
module prog_clock_divider #(
  parameter int WIDTH           = 20,
  parameter int DEFAULT_DIVISOR = 1000,
  parameter int DEFAULT_HIGH    = 500
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_enable,
  input  logic             i_load,
`ifdef DIVIDER_SYNC_EN
  input  logic             i_sync,
`endif
  input  logic [WIDTH-1:0] i_divisor,
  input  logic [WIDTH-1:0] i_high,
  output logic             o_clock,
  output logic             o_tick,
  output logic             o_pending
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] div_q, div_d, high_q, high_d;
  logic [WIDTH-1:0] pdiv_q, pdiv_d, phigh_q, phigh_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;

  logic [WIDTH-1:0] ld_div, ld_high;
  logic             sync_w;
  logic             wrap;
  logic             apply;

`ifdef DIVIDER_SYNC_EN
  assign sync_w = i_sync;
`else
  assign sync_w = 1'b0;
`endif

  // Clamp on capture so the active config always yields 1 <= H <= D-1.
  always_comb begin
    ld_div  = (i_divisor < WIDTH'(2)) ? WIDTH'(2) : i_divisor;
    ld_high = i_high;
    if (i_high == '0)
      ld_high = WIDTH'(1);
    if (i_high >= ld_div)
      ld_high = ld_div - WIDTH'(1);
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    div_d   = div_q;
    high_d  = high_q;
    pdiv_d  = pdiv_q;
    phigh_d = phigh_q;
    pend_d  = pend_q;
    clk_d   = 1'b0;
    tick_d  = 1'b0;
    apply   = 1'b0;
    wrap    = (count_q == div_q - WIDTH'(1)) || sync_w;
    case (state_q)
      ST_IDLE: begin
        count_d = '0;
        apply   = pend_q;
        if (i_enable) begin
          state_d = ST_RUN;
          clk_d   = 1'b1;
          tick_d  = 1'b1;
        end
      end
      default: begin
        if (!i_enable) begin
          // Immediate park; may cut a high phase short.
          state_d = ST_IDLE;
          count_d = '0;
        end else if (wrap) begin
          count_d = '0;
          apply   = pend_q;
          clk_d   = 1'b1;
          tick_d  = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
          clk_d   = (count_d < high_q);
        end
      end
    endcase
    if (apply) begin
      div_d  = pdiv_q;
      high_d = phigh_q;
      pend_d = 1'b0;
    end
    // A load on the applying edge becomes the next pending config.
    if (i_load) begin
      pdiv_d  = ld_div;
      phigh_d = ld_high;
      pend_d  = 1'b1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      div_q   <= WIDTH'(DEFAULT_DIVISOR);
      high_q  <= WIDTH'(DEFAULT_HIGH);
      pdiv_q  <= WIDTH'(DEFAULT_DIVISOR);
      phigh_q <= WIDTH'(DEFAULT_HIGH);
      pend_q  <= 1'b0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      div_q   <= div_d;
      high_q  <= high_d;
      pdiv_q  <= pdiv_d;
      phigh_q <= phigh_d;
      pend_q  <= pend_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
    end
  end

  assign o_clock   = clk_q;
  assign o_tick    = tick_q;
  assign o_pending = pend_q;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Bench for prog_clock_divider: vector table, directed corner sequences, randomized run vs a period-level model.
module tb_prog_clock_divider;
  localparam int W = 20;

  logic         i_clock = 1'b0;
  logic         i_reset_n = 1'b0;
  logic         i_enable = 1'b0;
  logic         i_load = 1'b0;
  logic [W-1:0] i_divisor = '0;
  logic [W-1:0] i_high = '0;
`ifdef DIVIDER_SYNC_EN
  logic         i_sync = 1'b0;
`endif
  logic         o_clock, o_tick, o_pending;

  int checks = 0;
  int errors = 0;

  always #5 i_clock = ~i_clock;

  prog_clock_divider #(.WIDTH(W), .DEFAULT_DIVISOR(1000), .DEFAULT_HIGH(500)) dut (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_enable  (i_enable),
    .i_load    (i_load),
`ifdef DIVIDER_SYNC_EN
    .i_sync    (i_sync),
`endif
    .i_divisor (i_divisor),
    .i_high    (i_high),
    .o_clock   (o_clock),
    .o_tick    (o_tick),
    .o_pending (o_pending)
  );

  typedef struct {
    logic         en;
    logic         ld;
    logic [W-1:0] d;
    logic [W-1:0] h;
    logic         e_clk;
    logic         e_tick;
    logic         e_pend;
  } vec_t;

  vec_t tbl[15];
  logic [2:0] exp_q[$];

  // Reference model: position within the period plus active/pending config.
  int m_run, m_phase, m_d, m_h, m_pend, m_pd, m_ph;

  function automatic vec_t mk(input int en, ld, d, h, c, t, p);
    vec_t v;
    v.en = 1'(en); v.ld = 1'(ld); v.d = W'(d); v.h = W'(h);
    v.e_clk = 1'(c); v.e_tick = 1'(t); v.e_pend = 1'(p);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  task automatic drive(input logic en, input logic ld, input int d, input int h);
    i_enable = en; i_load = ld; i_divisor = W'(d); i_high = W'(h);
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    drive(1'b0, 1'b0, 0, 0);
`ifdef DIVIDER_SYNC_EN
    i_sync = 1'b0;
`endif
    repeat (2) step();
    i_reset_n = 1'b1;
    m_run = 0; m_phase = 0; m_d = 1000; m_h = 500; m_pend = 0; m_pd = 1000; m_ph = 500;
  endtask

  task automatic wait_tick(input string name, input int bound);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!o_tick && n < bound);
    chk(name, 32'(o_tick), 1);
  endtask

  task automatic capture(input int n, output logic [31:0] cp, output logic [31:0] tp);
    cp = '0; tp = '0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) step();
      cp = {cp[30:0], o_clock};
      tp = {tp[30:0], o_tick};
    end
  endtask

  task automatic model_step(input int en, input int ld, input int d, input int h, input int sy);
    int cd, ch;
    if (m_run != 0 && en == 0) begin
      m_run = 0;
    end else if (m_run == 0) begin
      if (m_pend != 0) begin m_d = m_pd; m_h = m_ph; m_pend = 0; end
      if (en != 0) begin m_run = 1; m_phase = 0; end
    end else begin
      m_phase = (sy != 0) ? 0 : (m_phase + 1) % m_d;
      if (m_phase == 0 && m_pend != 0) begin m_d = m_pd; m_h = m_ph; m_pend = 0; end
    end
    if (ld != 0) begin
      cd = (d < 2) ? 2 : d;
      ch = (h < 1) ? 1 : h;
      if (ch > cd - 1) ch = cd - 1;
      m_pd = cd; m_ph = ch; m_pend = 1;
    end
  endtask

  initial begin
    #1_500_000;
    errors++;
    $display("FAIL watchdog simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] cp, tp;
    int highs, ticks, t2, first_low, bad;

    // en, ld, d, h -> clock, tick, pending after the edge
    tbl[0]  = mk(0, 1, 4, 9, 0, 0, 1);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 0, 0, 0, 1, 1, 0);
    tbl[3]  = mk(1, 0, 0, 0, 1, 0, 0);
    tbl[4]  = mk(1, 0, 0, 0, 1, 0, 0);
    tbl[5]  = mk(1, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(1, 0, 0, 0, 1, 1, 0);
    tbl[7]  = mk(1, 1, 0, 0, 1, 0, 1);
    tbl[8]  = mk(1, 0, 0, 0, 1, 0, 1);
    tbl[9]  = mk(1, 0, 0, 0, 0, 0, 1);
    tbl[10] = mk(1, 0, 0, 0, 1, 1, 0);
    tbl[11] = mk(1, 0, 0, 0, 0, 0, 0);
    tbl[12] = mk(1, 0, 0, 0, 1, 1, 0);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0);

    do_reset();
    chk("reset_clock", 32'(o_clock), 0);
    chk("reset_tick", 32'(o_tick), 0);
    chk("reset_pending", 32'(o_pending), 0);

    foreach (tbl[i]) begin
      i_enable = tbl[i].en; i_load = tbl[i].ld; i_divisor = tbl[i].d; i_high = tbl[i].h;
      step();
      chk($sformatf("tbl%0d_clock", i), 32'(o_clock), 32'(tbl[i].e_clk));
      chk($sformatf("tbl%0d_tick", i), 32'(o_tick), 32'(tbl[i].e_tick));
      chk($sformatf("tbl%0d_pending", i), 32'(o_pending), 32'(tbl[i].e_pend));
    end

    // Default 1000/500 timing from enable.
    do_reset();
    drive(1'b1, 1'b0, 0, 0);
    highs = 0; ticks = 0; t2 = -1; first_low = -1;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (i == 0) chk("first_tick", 32'(o_tick), 1);
      highs += int'(o_clock);
      if (o_tick) begin
        ticks++;
        if (ticks == 2) t2 = i;
      end
      if (!o_clock && first_low < 0) first_low = i;
    end
    chk("dflt_first_low", 32'(first_low), 500);
    chk("dflt_high_count", 32'(highs), 1000);
    chk("dflt_tick_count", 32'(ticks), 2);
    chk("dflt_tick_spacing", 32'(t2), 1000);

    // Mid-period load of 5/2 waits for the wrap.
    step();
    drive(1'b1, 1'b1, 5, 2);
    step();
    drive(1'b1, 1'b0, 0, 0);
    chk("load_pending_set", 32'(o_pending), 1);
    bad = 0;
    for (int n = 0; n < 1100 && !o_tick; n++) begin
      step();
      if (!o_tick && !o_pending) bad++;
    end
    chk("load_pending_held", 32'(bad), 0);
    chk("load_applied_tick", 32'(o_tick), 1);
    chk("load_pending_clear", 32'(o_pending), 0);
    capture(10, cp, tp);
    chk("d5_clock_pattern", cp, 32'b1100011000);
    chk("d5_tick_pattern", tp, 32'b1000010000);

    // Double load before the boundary: only 3/1 applies.
    step();
    drive(1'b1, 1'b1, 6, 2);
    step();
    drive(1'b1, 1'b1, 3, 1);
    step();
    drive(1'b1, 1'b0, 0, 0);
    wait_tick("dbl_wrap_tick", 10);
    chk("dbl_pending_clear", 32'(o_pending), 0);
    capture(9, cp, tp);
    chk("d3_clock_pattern", cp, 32'b100100100);
    chk("d3_tick_pattern", tp, 32'b100100100);

    // Enable drop at counter 2 of an 8/4 period, idle load, re-enable.
    drive(1'b1, 1'b1, 8, 4);
    step();
    drive(1'b1, 1'b0, 0, 0);
    wait_tick("d8_applied_tick", 10);
    step();
    step();
    drive(1'b0, 1'b0, 0, 0);
    step();
    chk("park_clock", 32'(o_clock), 0);
    capture(4, cp, tp);
    chk("park_clock_stays_low", cp, 0);
    drive(1'b0, 1'b1, 6, 3);
    step();
    chk("idle_load_pending", 32'(o_pending), 1);
    drive(1'b0, 1'b0, 0, 0);
    step();
    chk("idle_load_applied", 32'(o_pending), 0);
    drive(1'b1, 1'b0, 0, 0);
    step();
    capture(12, cp, tp);
    chk("reenable_clock_pattern", cp, 32'b111000111000);
    chk("reenable_tick_pattern", tp, 32'b100000100000);

    // Asynchronous reset in the middle of a high phase with a pending load.
    step();
    drive(1'b1, 1'b1, 9, 4);
    step();
    drive(1'b1, 1'b0, 0, 0);
    chk("pre_reset_clock", 32'(o_clock), 1);
    chk("pre_reset_pending", 32'(o_pending), 1);
    #2;
    i_reset_n = 1'b0;
    #1;
    chk("async_reset_clock", 32'(o_clock), 0);
    chk("async_reset_tick", 32'(o_tick), 0);
    chk("async_reset_pending", 32'(o_pending), 0);
    i_enable = 1'b0;
    step();
    i_reset_n = 1'b1;
    drive(1'b1, 1'b0, 0, 0);
    highs = 0; ticks = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      highs += int'(o_clock);
      ticks += int'(o_tick);
    end
    chk("post_reset_high_count", 32'(highs), 500);
    chk("post_reset_tick_count", 32'(ticks), 1);

`ifdef DIVIDER_SYNC_EN
    drive(1'b1, 1'b1, 8, 4);
    step();
    drive(1'b1, 1'b0, 0, 0);
    wait_tick("sync_d8_applied", 1100);
    repeat (3) step();
    i_sync = 1'b1;
    step();
    i_sync = 1'b0;
    chk("sync_tick", 32'(o_tick), 1);
    chk("sync_clock", 32'(o_clock), 1);
    step();
    chk("sync_next_tick", 32'(o_tick), 0);
`endif

    // Randomized run against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int en, ld, d, h, sy;
      logic [2:0] e;
      en = ($urandom_range(0, 19) != 0) ? 1 : 0;
      ld = ($urandom_range(0, 29) == 0) ? 1 : 0;
      d  = $urandom_range(0, 12);
      h  = $urandom_range(0, 14);
      sy = 0;
`ifdef DIVIDER_SYNC_EN
      sy = ($urandom_range(0, 49) == 0) ? 1 : 0;
      i_sync = 1'(sy);
`endif
      drive(1'(en), 1'(ld), d, h);
      @(posedge i_clock);
      model_step(en, ld, d, h, sy);
      exp_q.push_back({1'(m_run != 0 && m_phase < m_h), 1'(m_run != 0 && m_phase == 0), 1'(m_pend)});
      #1;
      e = exp_q.pop_front();
      chk("rnd_clock", 32'(o_clock), 32'(e[2]));
      chk("rnd_tick", 32'(o_tick), 32'(e[1]));
      chk("rnd_pending", 32'(o_pending), 32'(e[0]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
